imm_extend_pipe: RTL and testbench
==================================

// Module: imm_extend_pipe
// PURPOSE
//  Parametrised, pipelined immediate-extension unit; replaces the fixed 17->32 sign extender.
//  Sits between decode and the ALU operand mux. Immediates arrive through a valid/ready handshake,
//  are extended per a per-transaction mode, and leave through a registered 2-entry skid buffer.
//  Provides sign, zero, upper-load and branch-offset forms, plus a truncation flag.
// PARAMETERS
//  IN_W      17  immediate input width; 2 <= IN_W < OUT_W
//  OUT_W     32  extended output width
//  UPPER_SH  16  left shift applied in MODE_UPPER; 0 < UPPER_SH < OUT_W
// PORTS
//  clock      in   1      rising-edge clock
//  reset_n    in   1      asynchronous, active-low reset
//  in_valid   in   1      input transaction present
//  in_ready   out  1      unit can accept; transfer when in_valid && in_ready
//  in_imm     in   IN_W   raw immediate
//  in_mode    in   2      00 SIGN, 01 ZERO, 10 UPPER, 11 BRANCH
//  out_valid  out  1      out_data/out_trunc valid
//  out_ready  in   1      consumer accepts; transfer when out_valid && out_ready
//  out_data   out  OUT_W  extended result
//  out_trunc  out  1      nonzero/non-sign bits were lost while forming out_data
// BEHAVIOUR
//  Reset (reset_n low, any time, async): both buffer entries invalid; out_valid=0, in_ready=1,
//   out_data=0, out_trunc=0. In-flight data is discarded. First accept is allowed on the first
//   rising edge after reset_n deasserts.
//  Arithmetic (combinational on accept; result stored, never recomputed):
//   SIGN:   out = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm}; trunc=0
//   ZERO:   out = {{(OUT_W-IN_W){1'b0}}, imm}; trunc=0
//   UPPER:  out = zero-extended imm << UPPER_SH, low OUT_W bits kept; trunc=1 iff any bit of imm
//           at position >= OUT_W-UPPER_SH is 1
//   BRANCH: s = SIGN result; out = s << 2; trunc=1 iff s[OUT_W-1], s[OUT_W-2], s[OUT_W-3]
//           are not all equal
//  Buffer: entries MAIN (drives outputs) and SKID. States by occupancy: EMPTY, ONE (MAIN valid),
//   FULL (MAIN+SKID valid).
//   EMPTY: accept -> MAIN, go ONE.
//   ONE: out xfer only -> EMPTY; accept only -> SKID, go FULL; both -> new data into MAIN, stay ONE.
//   FULL: out xfer -> SKID moves to MAIN, go ONE; no accept possible.
//  in_ready = !FULL (registered-state only, no combinational path from out_ready).
//  out_valid = (state != EMPTY). out_data/out_trunc are registered, held stable while
//   out_valid && !out_ready.
//  Latency: accept at edge N -> out_valid at edge N (visible cycle N+1) when empty; throughput
//   1 transaction/cycle with out_ready held high.
//  Ordering: strictly FIFO; no transaction dropped or duplicated.
//  When out_valid=0, out_data/out_trunc hold their last value (0 after reset).
//  in_mode/in_imm are ignored when in_valid=0; out_ready is ignored when out_valid=0.
// TESTING
//  1 Reset: reset_n=0 -> out_valid=0, in_ready=1, out_data=0; release, no input -> stays idle.
//  2 SIGN 17'd20 -> 32'd20, trunc=0; SIGN 17'b1_0101_0101_0101_0101 -> 32'hFFFF5555; ZERO same
//    imm -> 32'h00015555; one cycle accept-to-valid with out_ready=1.
//  3 UPPER 17'h0ABCD -> 32'hABCD0000, trunc=0; UPPER 17'h1ABCD -> 32'hABCD0000, trunc=1;
//    BRANCH 17'h1FFFF -> 32'hFFFFFFFC, trunc=0.
//  4 Backpressure: out_ready=0, push A,B,C on consecutive cycles -> A,B accepted, in_ready=0 from
//    cycle after B, C held; raise out_ready -> A,B,C delivered in order, none lost.
//  5 Streaming: out_ready=1, 8 back-to-back inputs -> in_ready never drops, 8 outputs in 8
//    consecutive cycles, values correct.
//  6 Reset mid-operation: buffer FULL, pulse reset_n low asynchronously between edges ->
//    out_valid=0, in_ready=1 immediately; subsequent push reaches output normally.

Source files
------------

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender: SIGN/ZERO/UPPER/BRANCH forms with a truncation flag,
// delivered through a registered two-entry (MAIN + SKID) output buffer.
module imm_extend_pipe #(
    parameter int unsigned IN_W     = 17,
    parameter int unsigned OUT_W    = 32,
    parameter int unsigned UPPER_SH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_trunc
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    localparam logic [1:0] MODE_SIGN   = 2'b00;
    localparam logic [1:0] MODE_ZERO   = 2'b01;
    localparam logic [1:0] MODE_UPPER  = 2'b10;
    localparam logic [1:0] MODE_BRANCH = 2'b11;

    logic [1:0]       state_q, state_d;
    logic [OUT_W-1:0] main_data_q, main_data_d;
    logic             main_trunc_q, main_trunc_d;
    logic [OUT_W-1:0] skid_data_q, skid_data_d;
    logic             skid_trunc_q, skid_trunc_d;

    logic [OUT_W-1:0]   sext, zext;
    logic [2*OUT_W-1:0] up_full;
    logic [OUT_W-1:0]   ext_data;
    logic               ext_trunc;
    logic               accept, xfer;

    // Upper form is shifted in a double-width word so every bit pushed past OUT_W
    // lands in the top half and feeds the truncation flag directly.
    always_comb begin
        sext      = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};
        zext      = {{(OUT_W-IN_W){1'b0}}, in_imm};
        up_full   = {{OUT_W{1'b0}}, zext} << UPPER_SH;
        ext_data  = sext;
        ext_trunc = 1'b0;
        case (in_mode)
            MODE_SIGN: begin
                ext_data  = sext;
                ext_trunc = 1'b0;
            end
            MODE_ZERO: begin
                ext_data  = zext;
                ext_trunc = 1'b0;
            end
            MODE_UPPER: begin
                ext_data  = up_full[OUT_W-1:0];
                ext_trunc = |up_full[2*OUT_W-1:OUT_W];
            end
            MODE_BRANCH: begin
                ext_data  = {sext[OUT_W-3:0], 2'b00};
                ext_trunc = !((sext[OUT_W-1] == sext[OUT_W-2]) &&
                              (sext[OUT_W-2] == sext[OUT_W-3]));
            end
            default: ;
        endcase
    end

    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_data_q;
    assign out_trunc = main_trunc_q;
    assign accept    = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;

    always_comb begin
        state_d      = state_q;
        main_data_d  = main_data_q;
        main_trunc_d = main_trunc_q;
        skid_data_d  = skid_data_q;
        skid_trunc_d = skid_trunc_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    main_data_d  = ext_data;
                    main_trunc_d = ext_trunc;
                    state_d      = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && xfer) begin
                    main_data_d  = ext_data;
                    main_trunc_d = ext_trunc;
                end else if (accept) begin
                    skid_data_d  = ext_data;
                    skid_trunc_d = ext_trunc;
                    state_d      = ST_FULL;
                end else if (xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (xfer) begin
                    main_data_d  = skid_data_q;
                    main_trunc_d = skid_trunc_q;
                    state_d      = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_EMPTY;
            main_data_q  <= '0;
            main_trunc_q <= 1'b0;
            skid_data_q  <= '0;
            skid_trunc_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            main_data_q  <= main_data_d;
            main_trunc_q <= main_trunc_d;
            skid_data_q  <= skid_data_d;
            skid_trunc_q <= skid_trunc_d;
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench for imm_extend_pipe: driver pushes model results on accept,
// an independent monitor pops and compares on every output transfer.
module tb_imm_extend_pipe;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [16:0] in_imm;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_trunc;

    int tests = 0;
    int fails = 0;
    logic [32:0] exp_q[$];
    bit          hold_prev = 1'b0;
    logic [32:0] prev_out;

    imm_extend_pipe #(.IN_W(17), .OUT_W(32), .UPPER_SH(16)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_imm   (in_imm),
        .in_mode  (in_mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_trunc(out_trunc)
    );

    always #5 clock = ~clock;

    // Reference: treat the immediate as an integer and range-check the result.
    function automatic logic [32:0] model(input logic [16:0] imm, input logic [1:0] mode);
        longint v;
        longint r;
        bit     t;
        v = imm[16] ? longint'(imm) - 131072 : longint'(imm);
        r = 0;
        t = 1'b0;
        case (mode)
            2'd0: r = v;
            2'd1: r = longint'(imm);
            2'd2: begin
                r = longint'(imm) * 65536;
                t = (r >= 64'h1_0000_0000);
            end
            default: begin
                r = v * 4;
                t = (v < -(64'sd1 << 29)) || (v >= (64'sd1 << 29));
            end
        endcase
        return {t, r[31:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [16:0] imm, input logic [1:0] mode,
                         input bit ordy, output bit acc);
        @(negedge clock);
        in_valid  = v;
        in_imm    = imm;
        in_mode   = mode;
        out_ready = ordy;
        #1;
        acc = v && in_ready;
        if (acc) exp_q.push_back(model(imm, mode));
    endtask

    task automatic idle_check(input string name, input logic [31:0] d, input logic t);
        @(negedge clock);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk({name, "_valid"}, 64'(out_valid), 64'd1);
        chk({name, "_data"}, 64'(out_data), 64'(d));
        chk({name, "_trunc"}, 64'(out_trunc), 64'(t));
    endtask

    task automatic drain(input string name);
        bit acc;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) drive(1'b0, '0, '0, 1'b1, acc);
        drive(1'b0, '0, '0, 1'b1, acc);
        chk({name, "_pending"}, 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: a transfer happens at the posedge following this sample point.
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clock);
            #2;
            if (reset_n) begin
                if (hold_prev && out_valid)
                    chk("hold_stable", 64'({out_trunc, out_data}), 64'(prev_out));
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_output", 64'({out_trunc, out_data}), 64'h1_FFFF_FFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("scoreboard", 64'({out_trunc, out_data}), 64'(e));
                    end
                end
                hold_prev = out_valid && !out_ready;
                prev_out  = {out_trunc, out_data};
            end else begin
                hold_prev = 1'b0;
            end
        end
    end

    initial begin
        bit acc;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_imm    = '0;
        in_mode   = '0;
        out_ready = 1'b0;

        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_trunc", 64'(out_trunc), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) drive(1'b0, '0, '0, 1'b1, acc);
        chk("idle_out_valid", 64'(out_valid), 64'd0);

        drive(1'b1, 17'd20, 2'd0, 1'b1, acc);
        chk("sign20_acc", 64'(acc), 64'd1);
        idle_check("sign20", 32'd20, 1'b0);
        drive(1'b1, 17'h15555, 2'd0, 1'b1, acc);
        idle_check("sign_neg", 32'hFFFF5555, 1'b0);
        drive(1'b1, 17'h15555, 2'd1, 1'b1, acc);
        idle_check("zero", 32'h00015555, 1'b0);
        drive(1'b1, 17'h0ABCD, 2'd2, 1'b1, acc);
        idle_check("upper", 32'hABCD0000, 1'b0);
        drive(1'b1, 17'h1ABCD, 2'd2, 1'b1, acc);
        idle_check("upper_tr", 32'hABCD0000, 1'b1);
        drive(1'b1, 17'h1FFFF, 2'd3, 1'b1, acc);
        idle_check("branch", 32'hFFFFFFFC, 1'b0);
        drain("directed");

        // Backpressure: A, B fill the buffer, C must stall until space frees.
        drive(1'b1, 17'h00011, 2'd0, 1'b0, acc);
        chk("bp_a_acc", 64'(acc), 64'd1);
        drive(1'b1, 17'h10022, 2'd3, 1'b0, acc);
        chk("bp_b_acc", 64'(acc), 64'd1);
        drive(1'b1, 17'h1F033, 2'd2, 1'b0, acc);
        chk("bp_c_stalled", 64'(in_ready), 64'd0);
        acc = 1'b0;
        for (int i = 0; i < 6 && !acc; i++) drive(1'b1, 17'h1F033, 2'd2, 1'b1, acc);
        chk("bp_c_acc", 64'(acc), 64'd1);
        drain("bp");

        // Streaming: eight back-to-back with the consumer always ready.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 17'($urandom), 2'($urandom), 1'b1, acc);
            chk("stream_acc", 64'(acc), 64'd1);
            if (i > 0) chk("stream_valid", 64'(out_valid), 64'd1);
        end
        @(negedge clock);
        in_valid = 1'b0;
        #1;
        chk("stream_last_valid", 64'(out_valid), 64'd1);
        drain("stream");

        // Asynchronous reset while FULL.
        drive(1'b1, 17'h00AAA, 2'd1, 1'b0, acc);
        drive(1'b1, 17'h15555, 2'd3, 1'b0, acc);
        @(negedge clock);
        in_valid = 1'b0;
        #3;
        chk("full_in_ready", 64'(in_ready), 64'd0);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_out_data", 64'(out_data), 64'd0);
        exp_q.delete();
        hold_prev = 1'b0;
        #1;
        reset_n = 1'b1;
        drive(1'b1, 17'h00123, 2'd2, 1'b1, acc);
        chk("post_rst_acc", 64'(acc), 64'd1);
        idle_check("post_rst", 32'h01230000, 1'b0);
        drain("post_rst");

        // Random traffic with random backpressure.
        for (int i = 0; i < 400; i++)
            drive($urandom_range(0, 3) != 0, 17'($urandom), 2'($urandom),
                  $urandom_range(0, 3) != 0, acc);
        drain("random");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
